// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two-requester front end feeding one radix-2 Booth multiplier.
// A requester is granted in IDLE. The multiplier then runs WIDTH Booth steps (RUN).
// The product is held in DONE until the consumer takes it.
// Optional feature: define BOOTH_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise requester 0 always wins ties.
module booth_mul_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_m,
  input  logic [WIDTH-1:0]     req0_q,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_m,
  input  logic [WIDTH-1:0]     req1_q,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH:0]   a_reg;      // accumulator, one guard bit so M = -2^(WIDTH-1) is exact
  logic [WIDTH:0]   m_reg;      // sign-extended multiplicand
  logic [WIDTH-1:0] q_reg;
  logic             qm1_reg;
  logic [CW-1:0]    count_reg;
  logic             id_reg;

  logic             grant1;     // 1 selects requester 1, 0 selects requester 0
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] m_sel;
  logic [WIDTH-1:0] q_sel;
  logic             last_step;

`ifdef BOOTH_ARB_RR_EN
  logic last_reg;               // requester served most recently

  // Remember who was served; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
    end else if (accept) begin
      last_reg <= grant1;
    end
  end

  // Lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant1 = ~last_reg;
    if (req1_valid && !req0_valid) begin
      grant1 = 1'b1;
    end else if (req0_valid && !req1_valid) begin
      grant1 = 1'b0;
    end
  end
`else
  // Fixed priority: requester 1 only when it is the sole requester.
  assign grant1 = req1_valid && !req0_valid;
`endif

  assign req0_ready = (state_reg == IDLE) && !rst && !grant1;
  assign req1_ready = (state_reg == IDLE) && !rst && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign m_sel      = grant1 ? req1_m : req0_m;
  assign q_sel      = grant1 ? req1_q : req0_q;
  assign last_step  = (count_reg == CW'(WIDTH - 1));

  // Booth add/subtract selected by the current multiplier bit pair.
  always_comb begin
    sum = a_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg - m_reg;
      default: sum = a_reg;
    endcase
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand load on acceptance, then one step plus arithmetic shift per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      qm1_reg   <= 1'b0;
      count_reg <= '0;
      id_reg    <= 1'b0;
    end else if (accept) begin
      a_reg     <= '0;
      m_reg     <= {m_sel[WIDTH-1], m_sel};
      q_reg     <= q_sel;
      qm1_reg   <= 1'b0;
      count_reg <= '0;
      id_reg    <= grant1;
    end else if (state_reg == RUN) begin
      a_reg     <= {sum[WIDTH], sum[WIDTH:1]};
      q_reg     <= {sum[0], q_reg[WIDTH-1:1]};
      qm1_reg   <= q_reg[0];
      count_reg <= count_reg + CW'(1);
    end
  end

  assign rsp_valid   = (state_reg == DONE);
  assign rsp_id      = id_reg;
  assign rsp_product = {a_reg[WIDTH-1:0], q_reg};
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: the driver predicts the winner and
// product with plain arithmetic, and a monitor checks every response.
module tb_booth_mul_arbiter;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [PW-1:0]    rsp_product;
  logic             busy;

  booth_mul_arbiter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_m      (req0_m),
    .req0_q      (req0_q),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_m      (req1_m),
    .req1_q      (req1_q),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [PW-1:0] prod;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   hs_cyc = -100;
  logic last_served = 1'b1;
  bit   rand_ready = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Cycle counter: value after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Optional random back-pressure on the response channel.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every presented response against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      check("rdy_low_in_done", {30'd0, req1_ready, req0_ready}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        if (!prev_valid) check("latency", cyc, sb[0].due);
        check("rsp_id", {31'd0, rsp_id}, {31'd0, sb[0].id});
        check("rsp_product", {{(32-PW){1'b0}}, rsp_product}, {{(32-PW){1'b0}}, sb[0].prod});
        if (rsp_ready) begin
          $display("rsp id=%0d product=0x%0h cycle=%0d", rsp_id, rsp_product, cyc + 1);
          hs_cyc = cyc + 1;
          void'(sb.pop_front());
        end
      end
    end
    prev_valid = rsp_valid;
  end

  // Present a request pattern, wait for its acceptance, record the expectation.
  task automatic issue(input bit v0, input int m0, input int q0,
                       input bit v1, input int m1, input int q1, input bit chk_b2b);
    logic w;
    int   prod;
    int   acc;
    bit   got = 1'b0;
    req0_valid = v0;
    req0_m     = WIDTH'(m0);
    req0_q     = WIDTH'(q0);
    req1_valid = v1;
    req1_m     = WIDTH'(m1);
    req1_q     = WIDTH'(q1);
    if (v0 && !v1) w = 1'b0;
    else if (v1 && !v0) w = 1'b1;
    else begin
`ifdef BOOTH_ARB_RR_EN
      w = ~last_served;
`else
      w = 1'b0;
`endif
    end
    prod = w ? (m1 * q1) : (m0 * q0);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) got = 1'b1;
    end
    check("accept_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check("grant", {30'd0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
      acc = cyc + 1;
      if (chk_b2b) check("b2b_accept", acc, hs_cyc + 1);
      sb.push_back('{w, PW'(prod), acc + WIDTH});
      last_served = w;
      $display("req id=%0d m=%0d q=%0d expect=0x%0h accept_cycle=%0d",
               w, w ? m1 : m0, w ? q1 : q0, PW'(prod), acc);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_m = WIDTH'($urandom);
    req0_q = WIDTH'($urandom);
    req1_m = WIDTH'($urandom);
    req1_q = WIDTH'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    bit  v0, v1;

    // Reset: readies low while rst is high, then clean idle state.
    repeat (2) begin
      @(negedge clk);
      check("rst_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_product", {{(32-PW){1'b0}}, rsp_product}, 32'd0);
    @(posedge clk);
    #1;

    // Both requesters contending for four transactions.
    for (int k = 0; k < 4; k++)
      issue(1'b1, k + 1, 3, 1'b1, -(k + 2), 5, 1'b0);
    drain();

    // Single request, full handshake, busy length.
    issue(1'b1, -7, 3, 1'b0, 0, 0, 1'b0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("busy_cycles", n, WIDTH + 1);
    @(posedge clk);
    #1;

    // Back-to-back on requester 1.
    issue(1'b0, 0, 0, 1'b1, 4, 2, 1'b0);
    issue(1'b0, 0, 0, 1'b1, -5, -2, 1'b1);
    issue(1'b0, 0, 0, 1'b1, -4, -2, 1'b1);

    // Corner operands.
    issue(1'b1, -8, -8, 1'b0, 0, 0, 1'b1);
    issue(1'b1, -8, 7, 1'b0, 0, 0, 1'b1);
    issue(1'b1, 7, -8, 1'b0, 0, 0, 1'b1);
    issue(1'b1, 0, -8, 1'b0, 0, 0, 1'b1);
    drain();

    // Response stalled for three cycles in DONE.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue(1'b1, 5, -3, 1'b0, 0, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("stall_rsp_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_after_stall", {31'd0, busy}, 32'd0);
    drain();

    // Reset pulse after two Booth steps aborts the operation.
    @(posedge clk);
    #1;
    issue(1'b1, 6, 5, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    last_served = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    issue(1'b1, 3, 3, 1'b0, 0, 0, 1'b0);
    drain();

    // Randomized traffic with random response back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      issue(v0, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
            v1, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b0);
    end
    rand_ready = 1'b0;
    rsp_ready  = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
